// File: rtl/boot_copier.sv
// Start-up loader: copies the initialized-data image from instruction ROM into
// data RAM while holding the core in reset, then hands both memories to the core.
module boot_copier #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned AWIDTH      = 12,
    parameter int unsigned SRC_BASE    = 'h800,
    parameter int unsigned COPY_BYTES  = 2 ** AWIDTH,
    parameter logic [2:0]  WE_WORD     = 3'b110,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_req,
    output logic              core_rst_n,
    output logic              boot_busy,
    output logic              boot_done,
    input  logic [AWIDTH-1:0] core_inst_addr,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [AWIDTH-1:0] core_dmem_addr,
    input  logic [XLEN-1:0]   core_dmem_wdata,
    input  logic [2:0]        core_dmem_we,
    input  logic [XLEN-1:0]   rom_data,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    output logic [2:0]        ram_we
);

    localparam int unsigned NumWords = COPY_BYTES / 4;
    localparam int unsigned CntW     = $clog2(NumWords + 1);
    localparam int unsigned HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AWIDTH-1:0] SrcBase = AWIDTH'(SRC_BASE);

    // The last write and the core reset release must never share a cycle.
    if (HOLD_CYCLES == 0) begin : gen_hold_check
        $error("boot_copier: HOLD_CYCLES must be at least 1");
    end
    if ((COPY_BYTES % 4) != 0 || COPY_BYTES == 0) begin : gen_bytes_check
        $error("boot_copier: COPY_BYTES must be a non-zero multiple of 4");
    end

    typedef enum logic [1:0] {StInit, StCopy, StHold, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic [CntW-1:0]   cnt_m1;
    logic [AWIDTH-1:0] rd_off, wr_off;

    // cnt_q counts COPY cycles; the write side lags the read side by one word
    // because of the ROM's registered output.
    assign cnt_m1 = cnt_q - CntW'(1);
    assign rd_off = AWIDTH'({cnt_q, 2'b00});
    assign wr_off = AWIDTH'({cnt_m1, 2'b00});

    // State, counters and the registered core reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            hold_q       <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // Next-state sequencing: INIT -> COPY (N+1 cycles) -> HOLD -> DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            StInit: begin
                state_d = StCopy;
                cnt_d   = '0;
            end
            StCopy: begin
                if (cnt_q == CntW'(NumWords)) begin
                    state_d = StHold;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
                    state_d = StDone;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StDone: begin
                if (boot_req) begin
                    state_d = StInit;
                    cnt_d   = '0;
                    hold_d  = '0;
                end
            end
            default: state_d = StInit;
        endcase
        core_rst_n_d = (state_d == StDone);
    end

    // Memory port ownership: loader drives during copy, core passes through in DONE.
    always_comb begin
        rom_addr  = SrcBase;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = '0;
        case (state_q)
            StCopy: begin
                rom_addr = SrcBase + rd_off;
                // Cycle 0 only issues the first read; no data is back yet.
                if (cnt_q != '0) begin
                    ram_addr  = wr_off;
                    ram_wdata = rom_data;
                    ram_we    = WE_WORD;
                end
            end
            StDone: begin
                rom_addr  = core_inst_addr;
                ram_addr  = core_dmem_addr;
                ram_wdata = core_dmem_wdata;
                ram_we    = core_dmem_we;
            end
            default: ;
        endcase
    end

    assign core_rst_n = core_rst_n_q;
    assign boot_busy  = (state_q != StDone);
    assign boot_done  = (state_q == StDone);

endmodule

// File: tb/tb_boot_copier.sv
// Bench for boot_copier: small ROM model with registered output, cycle-indexed
// expectation of the copy sequence, pass-through, reset abort and boot_req restart.
module tb_boot_copier;

    localparam int unsigned XL = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned SB = 'h20;
    localparam int unsigned CB = 64;
    localparam int unsigned NW = CB / 4;
    localparam int unsigned HC = 2;
    localparam int unsigned RELEASE = 1 + (NW + 1) + HC;

    logic          clk, rst_n, boot_req;
    logic          core_rst_n, boot_busy, boot_done;
    logic [AW-1:0] core_inst_addr, rom_addr, core_dmem_addr, ram_addr;
    logic [XL-1:0] core_dmem_wdata, rom_data, ram_wdata;
    logic [2:0]    core_dmem_we, ram_we;

    logic [XL-1:0] rom_mem [2**AW/4];
    logic [XL-1:0] exp_img [NW];

    int n_checks = 0;
    int n_errors = 0;

    boot_copier #(
        .XLEN(XL), .AWIDTH(AW), .SRC_BASE(SB), .COPY_BYTES(CB),
        .WE_WORD(3'b110), .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .boot_req(boot_req),
        .core_rst_n(core_rst_n), .boot_busy(boot_busy), .boot_done(boot_done),
        .core_inst_addr(core_inst_addr), .rom_addr(rom_addr),
        .core_dmem_addr(core_dmem_addr), .core_dmem_wdata(core_dmem_wdata),
        .core_dmem_we(core_dmem_we), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM, one cycle of read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr[AW-1:2]];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Place image word k at ROM byte (SB + 4k) mod 2**AW and record what RAM must receive.
    task automatic load_image(input bit fixed);
        for (int k = 0; k < NW; k++) begin
            int unsigned idx;
            idx = ((SB + 4 * k) % (2 ** AW)) / 4;
            rom_mem[idx] = fixed ? (32'hA500_0000 + k) : $urandom;
        end
        for (int k = 0; k < NW; k++) exp_img[k] = rom_mem[((SB + 4 * k) % (2 ** AW)) / 4];
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_rst_n"}, core_rst_n, 0);
        check({tag, "_busy"}, boot_busy, 1);
        check({tag, "_done"}, boot_done, 0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_rom_addr"}, rom_addr, SB);
    endtask

    // Called while the INIT cycle is in progress. Cycle c is the interval after
    // edge c; write k is expected in cycle k+2. stop_after >= 0 returns right
    // after write stop_after has been presented.
    task automatic observe_boot(input string tag, input int stop_after);
        int cycles;
        cycles = 0;
        for (int c = 1; c <= 60; c++) begin
            logic [AW-1:0] exp_ra;
            @(posedge clk);
            #1;
            if (core_rst_n) begin
                cycles = c;
                break;
            end
            check({tag, "_busy"}, boot_busy, 1);
            check({tag, "_done"}, boot_done, 0);
            if (c <= NW) begin
                exp_ra = AW'((SB + 4 * (c - 1)) % (2 ** AW));
                check({tag, "_rom_addr"}, rom_addr, exp_ra);
            end
            if (c >= 2 && c <= NW + 1) begin
                check({tag, "_wr_we"}, ram_we, 3'b110);
                check({tag, "_wr_addr"}, ram_addr, 4 * (c - 2));
                check({tag, "_wr_data"}, ram_wdata, exp_img[c - 2]);
                if (stop_after >= 0 && c - 2 == stop_after) return;
            end else begin
                check({tag, "_we_idle"}, ram_we, 0);
            end
            #1;
            core_dmem_we    = 3'b110;
            core_dmem_addr  = AW'('h3C);
            core_dmem_wdata = $urandom;
            core_inst_addr  = AW'($urandom);
            boot_req        = 1'($urandom_range(0, 1));
        end
        boot_req = 1'b0;
        check({tag, "_release_cycles"}, cycles, RELEASE);
        check({tag, "_done_at_release"}, boot_done, 1);
        check({tag, "_busy_at_release"}, boot_busy, 0);
    endtask

    task automatic request_boot(input string tag);
        @(negedge clk);
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
        check({tag, "_req_core_rst_n"}, core_rst_n, 0);
        check({tag, "_req_busy"}, boot_busy, 1);
        check({tag, "_req_rom_addr"}, rom_addr, SB);
    endtask

    initial begin
        rst_n           = 1'b0;
        boot_req        = 1'b0;
        core_inst_addr  = '0;
        core_dmem_addr  = '0;
        core_dmem_wdata = '0;
        core_dmem_we    = '0;
        load_image(1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");

        @(negedge clk);
        rst_n = 1'b1;
        observe_boot("boot0", -1);

        // Pass-through: fixed pattern first, then random ones.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            core_dmem_addr  = (i == 0) ? AW'('h3C) : AW'($urandom);
            core_dmem_wdata = (i == 0) ? 32'h1234_5678 : $urandom;
            core_dmem_we    = (i == 0) ? 3'b110 : 3'($urandom);
            core_inst_addr  = (i == 0) ? AW'('h10) : AW'($urandom);
            #1;
            check("pt_ram_addr", ram_addr, core_dmem_addr);
            check("pt_ram_wdata", ram_wdata, core_dmem_wdata);
            check("pt_ram_we", ram_we, core_dmem_we);
            check("pt_rom_addr", rom_addr, core_inst_addr);
            check("pt_done", boot_done, 1);
        end

        // Restart, then abort with rst_n after write 5 and re-run from scratch.
        load_image(1'b0);
        request_boot("abort");
        observe_boot("abort_part", 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        observe_boot("after_abort", -1);

        // boot_req restart with yet another image.
        load_image(1'b0);
        request_boot("recopy");
        observe_boot("recopy", -1);

        repeat (3) @(posedge clk);
        #1;
        check("final_done", boot_done, 1);
        check("final_core_rst_n", core_rst_n, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/boot_copier.md
Name: boot_copier

Overview:
- Synthesizable start-up loader between top_core and the rom/ram pair. Replaces the bench-forced ROM-to-RAM preload.
- After reset it holds the core in reset and reads the initialized-data image from instruction ROM starting at SRC_BASE. It writes that image word by word into data RAM from address 0, then releases the core.
- While idle it is a transparent pass-through for the core's ROM and RAM ports.

Parameters:
- XLEN, 32, data word width.
- AWIDTH, 12, byte-address width of rom and ram.
- SRC_BASE, 'h800, ROM byte offset of the data image.
- COPY_BYTES, 2**AWIDTH, bytes copied (multiple of 4).
- WE_WORD, 3'b110, ram we encoding for a 32-bit store.
- HOLD_CYCLES, 2, extra cycles core_rst_n stays low after the last write.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- boot_req  in  1  pulse in DONE: restart full copy
- core_rst_n  out  1  registered reset to top_core
- boot_busy  out  1  high while copying or holding
- boot_done  out  1  high in DONE
- core_inst_addr  in  AWIDTH  core fetch address
- rom_addr  out  AWIDTH  to rom addr
- core_dmem_addr  in  AWIDTH  core data address
- core_dmem_wdata  in  XLEN  core store data
- core_dmem_we  in  3  core write enable
- rom_data  in  XLEN  rom qout, registered, 1-cycle latency
- ram_addr  out  AWIDTH  to ram addr
- ram_wdata  out  XLEN  to ram qin
- ram_we  out  3  to ram we

Behaviour:
- Reset (rst_n=0, async):
  - state=INIT, core_rst_n=0, boot_busy=1, boot_done=0.
  - ram_we=0, rom_addr=SRC_BASE, rd_cnt=wr_cnt=0.
- States: INIT -> COPY -> HOLD -> DONE; DONE --boot_req--> INIT.
- INIT (1 cycle): rom_addr=SRC_BASE, ram_we=0. Next state is COPY.
- COPY, read side: cycle k (k=0..N-1, N=COPY_BYTES/4) drives rom_addr=SRC_BASE+4k.
- COPY, write side: cycle k+1 drives ram_addr=4k, ram_wdata=rom_data, ram_we=WE_WORD.
- Throughput is one word per clock. Total COPY length is N+1 cycles.
- Leave COPY the cycle after write N-1.
- ram_we=0 in every cycle without a valid write, including the first COPY cycle.
- Address arithmetic is modulo 2**AWIDTH. SRC_BASE+4k wraps silently; no error is flagged.
- HOLD: ram_we=0, core_rst_n=0 for exactly HOLD_CYCLES cycles, then DONE.
- DONE:
  - core_rst_n=1 (registered, rises on the clock entering DONE); boot_busy=0, boot_done=1.
  - Pass-through: rom_addr=core_inst_addr, ram_addr=core_dmem_addr, ram_wdata=core_dmem_wdata, ram_we=core_dmem_we (combinational mux).
- Outside DONE, core_* inputs are ignored and the loader owns both memories.
- boot_req is sampled only in DONE. In DONE, boot_req=1 gives INIT next cycle with core_rst_n=0 at that edge and counters cleared. Ignored elsewhere.
- rst_n low mid-COPY/HOLD: immediate return to INIT values. The copy restarts from word 0 after release; partial RAM contents are overwritten.
- rst_n deasserted: first INIT cycle is the first rising clk with rst_n=1.
- The last write and the core_rst_n release never coincide; HOLD_CYCLES >= 1 is enforced by a parameter check.

Test Plan:
- AWIDTH=6, COPY_BYTES=64, SRC_BASE='h20, ROM word at 'h20+4k = 'hA5000000+k, release rst_n. Required:
  - ram receives 16 writes, addr 0,4,..,60, data 'hA5000000..'hA500000F, we=3'b110 on consecutive clocks.
  - ram_we=0 before the first write.
- Same run, count cycles from reset release to core_rst_n rise. Required: 1+17+2 = 20 clocks.
  - boot_done rises the same edge; boot_busy falls.
- In DONE, drive core_dmem_addr='h3C, wdata='h12345678, we=3'b110, and core_inst_addr='h10. Required: identical values on ram_* and rom_addr in the same cycle.
- In COPY, drive core_dmem_we=3'b110 and core_dmem_addr='h3C. Required: ram_we reflects only loader writes, and core signals never reach ram.
- Pulse rst_n low after write 5, then release. Required:
  - outputs return to reset values asynchronously.
  - the copy restarts at ram_addr 0, all 16 words correct, 20-clock release.
- In DONE, pulse boot_req for 1 cycle. Required:
  - core_rst_n=0 next edge, full 16-word recopy, core_rst_n=1 after 20 clocks.
  - boot_req pulsed during COPY has no effect.
